// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default sample width and the complex sample type.
package fft_pkg;
  localparam int FFT_DATA_W = 16;

  typedef struct packed {
    logic signed [FFT_DATA_W-1:0] re;
    logic signed [FFT_DATA_W-1:0] im;
  } cplx_t;
endpackage

// File: rtl/delay_line.sv
// Enabled shift register: dout is the word accepted DEPTH enables earlier.
module delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (en) begin
      mem_d[0] = din;
      for (int i = 1; i < DEPTH; i++) mem_d[i] = mem_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  assign dout = mem_q[DEPTH-1];
endmodule

// File: rtl/delay_commutator.sv
// MDC delay commutator: x0 -> delay D -> swap with x1 -> lower path delay D.
// Self-timed by a mod-2D sample counter; stalls freeze all state.
module delay_commutator
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int LOG2D  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     frame_start,
  input  logic signed [DATA_W-1:0] x0_re,
  input  logic signed [DATA_W-1:0] x0_im,
  input  logic signed [DATA_W-1:0] x1_re,
  input  logic signed [DATA_W-1:0] x1_im,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] y0_re,
  output logic signed [DATA_W-1:0] y0_im,
  output logic signed [DATA_W-1:0] y1_re,
  output logic signed [DATA_W-1:0] y1_im
);
  localparam int D  = 2 ** LOG2D;
  localparam int CW = LOG2D + 1;
  localparam logic [CW-1:0] PRIME_FULL = CW'(D);

  logic [CW-1:0]       cnt_q, cnt_d, cnt_cur;
  logic [CW-1:0]       prime_q, prime_d, prime_cur;
  logic                out_valid_q, out_valid_d;
  logic [2*DATA_W-1:0] y0_q, y0_d, y1_q, y1_d;
  logic [2*DATA_W-1:0] x0_w, x1_w, x0_dly, up_sw, lo_sw, lo_dly;
  logic                sel;

  assign x0_w = {x0_re, x0_im};
  assign x1_w = {x1_re, x1_im};

  delay_line #(.WIDTH(2*DATA_W), .DEPTH(D)) u_dly_x0 (
    .clk  (clk),
    .rst  (rst),
    .en   (in_valid),
    .din  (x0_w),
    .dout (x0_dly)
  );

  delay_line #(.WIDTH(2*DATA_W), .DEPTH(D)) u_dly_lo (
    .clk  (clk),
    .rst  (rst),
    .en   (in_valid),
    .din  (lo_sw),
    .dout (lo_dly)
  );

  always_comb begin
    // A frame start makes the current sample index 0 and restarts priming.
    cnt_cur     = frame_start ? '0 : cnt_q;
    prime_cur   = frame_start ? '0 : prime_q;
    sel         = cnt_cur[LOG2D];
    up_sw       = sel ? x1_w   : x0_dly;
    lo_sw       = sel ? x0_dly : x1_w;
    cnt_d       = cnt_q;
    prime_d     = prime_q;
    out_valid_d = 1'b0;
    y0_d        = y0_q;
    y1_d        = y1_q;
    if (in_valid) begin
      cnt_d       = cnt_cur + 1'b1;
      prime_d     = (prime_cur == PRIME_FULL) ? prime_cur : prime_cur + 1'b1;
      out_valid_d = (prime_cur == PRIME_FULL);
      y0_d        = up_sw;
      y1_d        = lo_dly;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      prime_q     <= '0;
      out_valid_q <= 1'b0;
      y0_q        <= '0;
      y1_q        <= '0;
    end else begin
      cnt_q       <= cnt_d;
      prime_q     <= prime_d;
      out_valid_q <= out_valid_d;
      y0_q        <= y0_d;
      y1_q        <= y1_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign {y0_re, y0_im} = y0_q;
  assign {y1_re, y1_im} = y1_q;
endmodule

// File: tb/tb_delay_commutator.sv
// Scoreboard bench for delay_commutator at D=1, D=2 and D=4.
module tb_delay_commutator;
  typedef struct packed {
    logic signed [15:0] y0re;
    logic signed [15:0] y0im;
    logic signed [15:0] y1re;
    logic signed [15:0] y1im;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic frame_start = 1'b0;
  logic signed [15:0] x0_re = '0, x0_im = '0, x1_re = '0, x1_im = '0;

  logic ov1, ov2, ov4;
  logic signed [15:0] y0r1, y0i1, y1r1, y1i1;
  logic signed [15:0] y0r2, y0i2, y1r2, y1i2;
  logic signed [15:0] y0r4, y0i4, y1r4, y1i4;

  always #5 clk = ~clk;

  delay_commutator #(.DATA_W(16), .LOG2D(0)) dut_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start),
    .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
    .out_valid(ov1), .y0_re(y0r1), .y0_im(y0i1), .y1_re(y1r1), .y1_im(y1i1));

  delay_commutator #(.DATA_W(16), .LOG2D(1)) dut_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start),
    .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
    .out_valid(ov2), .y0_re(y0r2), .y0_im(y0i2), .y1_re(y1r2), .y1_im(y1i2));

  delay_commutator #(.DATA_W(16), .LOG2D(2)) dut_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start),
    .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
    .out_valid(ov4), .y0_re(y0r4), .y0_im(y0i4), .y1_re(y1r4), .y1_im(y1i4));

  int   total = 0;
  int   bad = 0;
  int   cur_d = 4;
  int   n = 0;
  logic exp_v = 1'b0;
  logic hold_ok = 1'b0;
  exp_t last_e;
  exp_t e;
  exp_t sb[$];
  logic signed [15:0] h0re[$], h0im[$], h1re[$], h1im[$];

  logic obs_v;
  exp_t obs_y;
  always_comb begin
    obs_v = ov4;
    obs_y = {y0r4, y0i4, y1r4, y1i4};
    case (cur_d)
      1: begin obs_v = ov1; obs_y = {y0r1, y0i1, y1r1, y1i1}; end
      2: begin obs_v = ov2; obs_y = {y0r2, y0i2, y1r2, y1i2}; end
      default: ;
    endcase
  end

  task automatic clear_model();
    h0re.delete(); h0im.delete(); h1re.delete(); h1im.delete();
    sb.delete();
    hold_ok = 1'b0;
  endtask

  // Drive one cycle and extend the reference transfer-function model.
  task automatic step(input logic v, input logic fs, input int a_re, input int a_im,
                      input int b_re, input int b_im);
    exp_t ne;
    logic s;
    @(negedge clk);
    in_valid = v; frame_start = fs;
    x0_re = 16'(a_re); x0_im = 16'(a_im); x1_re = 16'(b_re); x1_im = 16'(b_im);
    exp_v = 1'b0;
    if (v) begin
      if (fs) begin
        h0re.delete(); h0im.delete(); h1re.delete(); h1im.delete();
      end
      h0re.push_back(16'(a_re)); h0im.push_back(16'(a_im));
      h1re.push_back(16'(b_re)); h1im.push_back(16'(b_im));
      n = h0re.size() - 1;
      if (n >= cur_d) begin
        s = ((n / cur_d) % 2) == 1;
        if (s) begin
          ne.y0re = h1re[n];         ne.y0im = h1im[n];
          ne.y1re = h1re[n-cur_d];   ne.y1im = h1im[n-cur_d];
        end else begin
          ne.y0re = h0re[n-cur_d];   ne.y0im = h0im[n-cur_d];
          ne.y1re = h0re[n-2*cur_d]; ne.y1im = h0im[n-2*cur_d];
        end
        sb.push_back(ne);
        last_e = ne;
        exp_v = 1'b1;
      end
      hold_ok = exp_v;
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; frame_start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({ov1, ov2, ov4} !== 3'b000) begin
      bad++; $display("FAIL reset_valid got=%b want=000", {ov1, ov2, ov4});
    end
    total++;
    if ({y0r1, y0i1, y1r1, y1i1, y0r2, y0i2, y1r2, y1i2} !== '0) begin
      bad++; $display("FAIL reset_y_d1d2 got=%h want=0", {y0r1, y0i1, y1r1, y1i1, y0r2, y0i2, y1r2, y1i2});
    end
    total++;
    if ({y0r4, y0i4, y1r4, y1i4} !== '0) begin
      bad++; $display("FAIL reset_y_d4 got=%h want=0", {y0r4, y0i4, y1r4, y1i4});
    end
  endtask

  task automatic test_stream(input int d, input int len);
    cur_d = d;
    apply_reset();
    for (int k = 0; k < len; k++) begin
      step(1'b1, 1'b0, k, -k, 100 + k, -(100 + k));
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL stream_d%0d_valid n=%0d got=%0b want=%0b", d, n, obs_v, exp_v);
      end
      if (exp_v) begin
        e = sb.pop_front();
        total++;
        if (obs_y !== e) begin
          bad++;
          $display("FAIL stream_d%0d_data n=%0d got=(%0d,%0d,%0d,%0d) want=(%0d,%0d,%0d,%0d)", d, n,
                   obs_y.y0re, obs_y.y0im, obs_y.y1re, obs_y.y1im, e.y0re, e.y0im, e.y1re, e.y1im);
        end
      end
    end
  endtask

  task automatic test_gaps();
    cur_d = 4;
    apply_reset();
    for (int k = 0; k < 14; k++) begin
      step(1'b1, 1'b0, k, -k, 100 + k, -(100 + k));
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL gaps_valid n=%0d got=%0b want=%0b", n, obs_v, exp_v);
      end
      if (exp_v) begin
        e = sb.pop_front();
        total++;
        if (obs_y !== e) begin
          bad++;
          $display("FAIL gaps_data n=%0d got=(%0d,%0d,%0d,%0d) want=(%0d,%0d,%0d,%0d)", n,
                   obs_y.y0re, obs_y.y0im, obs_y.y1re, obs_y.y1im, e.y0re, e.y0im, e.y1re, e.y1im);
        end
      end
      // Idle cycle with a stray frame_start that must be ignored.
      step(1'b0, (k % 3) == 1, 999, 999, 999, 999);
      total++;
      if (obs_v !== 1'b0) begin
        bad++; $display("FAIL gaps_idle_valid after n=%0d got=%0b want=0", n, obs_v);
      end
      if (hold_ok) begin
        total++;
        if (obs_y !== last_e) begin
          bad++;
          $display("FAIL gaps_hold after n=%0d got=(%0d,%0d) want=(%0d,%0d)", n,
                   obs_y.y0re, obs_y.y1re, last_e.y0re, last_e.y1re);
        end
      end
    end
  endtask

  task automatic test_frame_restart();
    logic fs;
    int   v;
    cur_d = 4;
    apply_reset();
    for (int k = 0; k < 18; k++) begin
      fs = (k == 6);
      v  = (k < 6) ? k : 200 + k;
      step(1'b1, fs, v, -v, 100 + v, -(100 + v));
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL frame_valid k=%0d n=%0d got=%0b want=%0b", k, n, obs_v, exp_v);
      end
      if (exp_v) begin
        e = sb.pop_front();
        total++;
        if (obs_y !== e) begin
          bad++;
          $display("FAIL frame_data k=%0d n=%0d got=(%0d,%0d,%0d,%0d) want=(%0d,%0d,%0d,%0d)", k, n,
                   obs_y.y0re, obs_y.y0im, obs_y.y1re, obs_y.y1im, e.y0re, e.y0im, e.y1re, e.y1im);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    cur_d = 4;
    apply_reset();
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 50 + k, 60 + k, 70 + k, 80 + k);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    total++;
    if (obs_v !== 1'b0) begin
      bad++; $display("FAIL midrst_valid got=%0b want=0", obs_v);
    end
    total++;
    if (obs_y !== '0) begin
      bad++; $display("FAIL midrst_y got=%h want=0", obs_y);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    clear_model();
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b0, k, -k, 100 + k, -(100 + k));
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL midrst_restart_valid n=%0d got=%0b want=%0b", n, obs_v, exp_v);
      end
      if (exp_v) begin
        e = sb.pop_front();
        total++;
        if (obs_y !== e) begin
          bad++;
          $display("FAIL midrst_restart_data n=%0d got=(%0d,%0d) want=(%0d,%0d)", n,
                   obs_y.y0re, obs_y.y1re, e.y0re, e.y1re);
        end
      end
    end
  endtask

  task automatic test_extremes();
    cur_d = 2;
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, -32768, -32768, 32767, 32767);
      total++;
      if (obs_v !== exp_v) begin
        bad++; $display("FAIL extreme_valid n=%0d got=%0b want=%0b", n, obs_v, exp_v);
      end
      if (exp_v) begin
        e = sb.pop_front();
        total++;
        if (obs_y !== e) begin
          bad++;
          $display("FAIL extreme_data n=%0d got=(%0d,%0d,%0d,%0d) want=(%0d,%0d,%0d,%0d)", n,
                   obs_y.y0re, obs_y.y0im, obs_y.y1re, obs_y.y1im, e.y0re, e.y0im, e.y1re, e.y1im);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream(1, 12);
    test_stream(4, 24);
    test_gaps();
    test_frame_restart();
    test_mid_reset();
    test_extremes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
